// File: rtl/data_bus_reg_responder_if.sv
// ibex_data_bus: request/grant/response data bus between a master (core or
// SoC arbiter) and a peripheral-side slave.
//
// Signals
//   req, we, be[3:0], addr[31:0], wdata[31:0], wdata_intg[6:0]  master -> slave
//   gnt, rvalid, rdata[31:0], rdata_intg[6:0], err              slave  -> master
interface ibex_data_bus;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  wdata_intg;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (
        output req, we, be, addr, wdata, wdata_intg,
        input  gnt, rvalid, rdata, rdata_intg, err
    );

    modport slave (
        input  req, we, be, addr, wdata, wdata_intg,
        output gnt, rvalid, rdata, rdata_intg, err
    );
endinterface

// File: rtl/data_bus_reg_responder.sv
// data_bus_reg_responder: generic peripheral-side register bank behind the
// ibex data bus. One transaction outstanding at a time, with optional grant
// and response wait states. Bus writes use byte enables; registers flagged in
// RO_MASK are read-only from the bus but still loadable by hardware.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   data_bus     ibex_data_bus slave modport
//   regs_o       register contents, register i at bits [32i+31:32i]
//   hw_we        per-register hardware load enable
//   hw_wdata     hardware load data, same packing as regs_o
//   wr_pulse     one-cycle strobe when a bus write to register i commits
//   rd_pulse     one-cycle strobe when a bus read of register i returns
//
// Build option
//   DATA_BUS_REG_RESPONDER_ERR_EN  when defined, out-of-range accesses and
//   writes to read-only registers answer with err = 1; otherwise err is 0
//   and such accesses are silently dropped / read as 0.
module data_bus_reg_responder #(
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter int                  GNT_WAIT = 0,
    parameter int                  RSP_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ibex_data_bus.slave              data_bus,
    output logic [NUM_REGS*32-1:0]   regs_o,
    input  logic [NUM_REGS-1:0]      hw_we,
    input  logic [NUM_REGS*32-1:0]   hw_wdata,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic [NUM_REGS-1:0]      rd_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_WAIT,
        RESPOND_WAIT,
        RESPOND
    } state_e;

    // Counters are loaded with (wait - 1) so that a wait of N costs exactly N cycles.
    localparam logic [3:0]  GNT_LOAD   = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;
    localparam logic [3:0]  RSP_LOAD   = (RSP_WAIT > 0) ? 4'(RSP_WAIT - 1) : 4'd0;
    localparam logic [10:0] NUM_REGS_L = 11'(NUM_REGS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant;

    logic        we_q;
    logic [3:0]  be_q;
    logic [9:0]  idx_q;
    logic [31:0] wdata_q;

    logic [31:0] regs [NUM_REGS];

    logic        rvalid;
    logic        in_range;
    logic        ro_sel;
    logic [31:0] sel_val;
    logic [31:0] merged;
    logic        bus_rd_ok;
    logic        bus_wr_ok;

    // The window has already been decoded upstream; only addr[11:2] matters.
    logic        unused_bits;
    assign unused_bits = ^{data_bus.addr[31:12], data_bus.addr[1:0], data_bus.wdata_intg};

    // ------------------------------------------------------------------
    // Handshake state machine
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_bus.req) begin
                    if (GNT_WAIT == 0) begin
                        grant = 1'b1;
                    end else begin
                        cnt_d   = GNT_LOAD;
                        state_d = GRANT_WAIT;
                    end
                end
            end
            GRANT_WAIT: begin
                if (!data_bus.req) begin
                    // Master abandoned the request: back off without side effects.
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    grant = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND_WAIT: begin
                if (cnt_q == 4'd0) state_d = RESPOND;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With no response wait the grant cycle is followed directly by rvalid.
        if (grant) begin
            cnt_d   = RSP_LOAD;
            state_d = (RSP_WAIT == 0) ? RESPOND : RESPOND_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= 10'd0;
            wdata_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                we_q    <= data_bus.we;
                be_q    <= data_bus.be;
                idx_q   <= data_bus.addr[11:2];
                wdata_q <= data_bus.wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the captured request
    // ------------------------------------------------------------------
    always_comb begin
        in_range = ({1'b0, idx_q} < NUM_REGS_L);
        ro_sel   = 1'b0;
        sel_val  = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 10'(i)) begin
                ro_sel  = RO_MASK[i];
                sel_val = regs[i];
            end
        end
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : sel_val[8*b +: 8];
        end
    end

    assign rvalid    = (state_q == RESPOND);
    assign bus_rd_ok = rvalid && !we_q && in_range;
    assign bus_wr_ok = rvalid &&  we_q && in_range && !ro_sel;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse[i] = bus_wr_ok && (idx_q == 10'(i));
            rd_pulse[i] = bus_rd_ok && (idx_q == 10'(i));
        end
    end

    assign data_bus.gnt        = grant;
    assign data_bus.rvalid     = rvalid;
    assign data_bus.rdata      = bus_rd_ok ? sel_val : 32'd0;
    assign data_bus.rdata_intg = 7'd0;
`ifdef DATA_BUS_REG_RESPONDER_ERR_EN
    assign data_bus.err        = rvalid && (!in_range || (we_q && ro_sel));
`else
    assign data_bus.err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Register bank: a committing bus write beats a hardware load; a
    // read-only register never sees a bus write, so hardware always wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is plain flops, not a RAM macro, so it can and
            // must be cleared by the asynchronous reset.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_pulse[i])   regs[i] <= merged;
                else if (hw_we[i]) regs[i] <= hw_wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs[i];
    end

endmodule

// File: tb/tb_data_bus_reg_responder.sv
module tb_data_bus_reg_responder;

`ifdef DATA_BUS_REG_RESPONDER_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;
    logic rst0_n, rst1_n;

    ibex_data_bus bus0 ();
    ibex_data_bus bus1 ();

    logic [255:0] regs0, regs1;
    logic [7:0]   hw_we0, hw_we1;
    logic [255:0] hw_wdata0, hw_wdata1;
    logic [7:0]   wr0, rd0, wr1, rd1;

    int checks = 0;
    int errors = 0;

    // Fast slave with register 0 read-only.
    data_bus_reg_responder #(
        .NUM_REGS(8), .RO_MASK(8'h01), .GNT_WAIT(0), .RSP_WAIT(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .data_bus(bus0.slave),
        .regs_o(regs0), .hw_we(hw_we0), .hw_wdata(hw_wdata0),
        .wr_pulse(wr0), .rd_pulse(rd0)
    );

    // Slow slave with grant and response wait states.
    data_bus_reg_responder #(
        .NUM_REGS(8), .RO_MASK(8'h00), .GNT_WAIT(3), .RSP_WAIT(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .data_bus(bus1.slave),
        .regs_o(regs1), .hw_we(hw_we1), .hw_wdata(hw_wdata1),
        .wr_pulse(wr1), .rd_pulse(rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        bus0.req = req; bus0.we = we; bus0.addr = addr; bus0.be = be; bus0.wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        bus1.req = req; bus1.we = we; bus1.addr = addr; bus1.be = be; bus1.wdata = wdata;
    endtask

    // Advance to the next falling edge; inputs change there, outputs are
    // sampled 1 ns later, well away from the rising edge.
    task automatic next_cycle;
        @(negedge clk);
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        bus0.wdata_intg = 7'h0; bus1.wdata_intg = 7'h0;
        hw_we0 = '0; hw_wdata0 = '0; hw_we1 = '0; hw_wdata1 = '0;

        // ---------------- reset state ----------------
        repeat (2) next_cycle();
        #1;
        check("rst_gnt",    256'(bus0.gnt),    256'(0));
        check("rst_rvalid", 256'(bus0.rvalid), 256'(0));
        check("rst_err",    256'(bus0.err),    256'(0));
        check("rst_rdata",  256'(bus0.rdata),  256'(0));
        check("rst_intg",   256'(bus0.rdata_intg), 256'(0));
        check("rst_regs",   regs0,             256'(0));
        check("rst_pulses", 256'({wr0, rd0}),  256'(0));
        next_cycle(); rst0_n = 1'b1; rst1_n = 1'b1;

        // ---------------- DUT0: write 0xDEADBEEF to reg1 ----------------
        next_cycle(); drive0(1'b1, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF); #1;
        check("w1_gnt",    256'(bus0.gnt),    256'(1));
        check("w1_rv0",    256'(bus0.rvalid), 256'(0));
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("w1_rvalid", 256'(bus0.rvalid), 256'(1));
        check("w1_gnt0",   256'(bus0.gnt),    256'(0));
        check("w1_wrp",    256'(wr0),         256'(8'h02));
        check("w1_rdata",  256'(bus0.rdata),  256'(0));
        check("w1_err",    256'(bus0.err),    256'(0));
        check("w1_notyet", 256'(regs0[63:32]), 256'(0));
        next_cycle(); #1;
        check("w1_reg1",   256'(regs0[63:32]), 256'(32'hDEADBEEF));
        check("w1_wrp0",   256'(wr0),          256'(0));
        check("w1_rv_end", 256'(bus0.rvalid),  256'(0));

        // ---------------- DUT0: read reg1 back ----------------
        drive0(1'b1, 1'b0, 32'h4, 4'hF, 32'h0); #1;
        check("r1_gnt",    256'(bus0.gnt),    256'(1));
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("r1_rvalid", 256'(bus0.rvalid), 256'(1));
        check("r1_rdata",  256'(bus0.rdata),  256'(32'hDEADBEEF));
        check("r1_rdp",    256'(rd0),         256'(8'h02));
        check("r1_wrp",    256'(wr0),         256'(0));
        next_cycle(); #1;
        check("r1_rdp0",   256'(rd0),         256'(0));

        // ---------------- DUT0: byte enables on reg2 ----------------
        hw_we0 = 8'h04; hw_wdata0[95:64] = 32'h11223344;
        next_cycle(); hw_we0 = 8'h00; #1;
        check("be_hwload", 256'(regs0[95:64]), 256'(32'h11223344));
        drive0(1'b1, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD);
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle(); #1;
        check("be_merge",  256'(regs0[95:64]), 256'(32'h11BB33DD));

        // ---------------- DUT0: write with be = 0 ----------------
        drive0(1'b1, 1'b1, 32'h4, 4'h0, 32'h0);
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("be0_rvalid", 256'(bus0.rvalid), 256'(1));
        check("be0_wrp",    256'(wr0),         256'(8'h02));
        next_cycle(); #1;
        check("be0_keep",   256'(regs0[63:32]), 256'(32'hDEADBEEF));

        // ---------------- DUT0: bus beats hardware on RW reg3 ----------------
        hw_we0 = 8'h08; hw_wdata0[127:96] = 32'h99;
        drive0(1'b1, 1'b1, 32'hC, 4'hF, 32'h55);
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("col_wrp",   256'(wr0), 256'(8'h08));
        next_cycle(); hw_we0 = 8'h00; #1;
        check("col_bus",   256'(regs0[127:96]), 256'(32'h55));

        // ---------------- DUT0: read-only reg0, hardware wins ----------------
        hw_we0 = 8'h01; hw_wdata0[31:0] = 32'h7;
        drive0(1'b1, 1'b1, 32'h0, 4'hF, 32'h5); #1;
        check("ro_gnt",    256'(bus0.gnt), 256'(1));
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("ro_rvalid", 256'(bus0.rvalid), 256'(1));
        check("ro_wrp",    256'(wr0),         256'(0));
        check("ro_err",    256'(bus0.err),    256'(EXP_ERR));
        next_cycle(); hw_we0 = 8'h00; #1;
        check("ro_reg0",   256'(regs0[31:0]), 256'(32'h7));

        // ---------------- DUT0: out-of-range read (index 16) ----------------
        drive0(1'b1, 1'b0, 32'h40, 4'hF, 32'h0); #1;
        check("oor_gnt",    256'(bus0.gnt), 256'(1));
        next_cycle(); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("oor_rvalid", 256'(bus0.rvalid), 256'(1));
        check("oor_err",    256'(bus0.err),    256'(EXP_ERR));
        check("oor_rdata",  256'(bus0.rdata),  256'(0));
        check("oor_rdp",    256'(rd0),         256'(0));

        // ---------------- DUT1: request dropped in GRANT_WAIT ----------------
        next_cycle(); drive1(1'b1, 1'b1, 32'hC, 4'hF, 32'hBAD0BAD0); #1;
        check("drop_gnt_c0", 256'(bus1.gnt), 256'(0));
        next_cycle(); drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        check("drop_gnt_c1", 256'(bus1.gnt), 256'(0));
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #1;
            check("drop_quiet", 256'({bus1.gnt, bus1.rvalid, wr1}), 256'(0));
        end
        check("drop_reg3", 256'(regs1[127:96]), 256'(0));

        // ---------------- DUT1: wait-state write to reg3 ----------------
        next_cycle(); drive1(1'b1, 1'b1, 32'hC, 4'hF, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            #1;
            check($sformatf("ws_gnt_c%0d", k), 256'(bus1.gnt), 256'(k == 3));
        end
        for (int k = 4; k < 8; k++) begin
            next_cycle(); drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
            check($sformatf("ws_rvalid_c%0d", k), 256'(bus1.rvalid), 256'(k == 6));
            check($sformatf("ws_wrp_c%0d", k),    256'(wr1), (k == 6) ? 256'(8'h08) : 256'(0));
        end
        check("ws_reg3", 256'(regs1[127:96]), 256'(32'h12345678));

        // ---------------- DUT1: reset during RESPOND_WAIT ----------------
        next_cycle(); drive1(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
        repeat (3) next_cycle();
        #1;
        check("rst_mid_gnt", 256'(bus1.gnt), 256'(1));
        next_cycle(); drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); rst1_n = 1'b0; #1;
        check("rst_mid_rv", 256'(bus1.rvalid), 256'(0));
        next_cycle(); #1;
        check("rst_mid_rv2", 256'(bus1.rvalid), 256'(0));
        rst1_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            check("rst_mid_quiet", 256'({bus1.rvalid, wr1}), 256'(0));
        end
        check("rst_mid_regs", regs1, 256'(0));

        // Next request after reset completes with normal timing.
        drive1(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        repeat (3) next_cycle();
        #1;
        check("post_gnt", 256'(bus1.gnt), 256'(1));
        next_cycle(); drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle(); #1;
        check("post_rv_early", 256'(bus1.rvalid), 256'(0));
        next_cycle(); #1;
        check("post_rvalid", 256'(bus1.rvalid), 256'(1));
        check("post_rdata",  256'(bus1.rdata),  256'(0));
        check("post_rdp",    256'(rd1),         256'(8'h10));
        next_cycle(); #1;
        check("post_idle",   256'(bus1.rvalid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_reg_responder.md
Name: data_bus_reg_responder

Overview:
- Generic peripheral-side responder for the ibex data bus: terminates req/gnt/rvalid transactions that the SoC data bus arbiter forwards to a peripheral.
- Holds a bank of NUM_REGS 32-bit registers with byte-enable writes and a read-only mask.
- Provides hardware-side update and access-strobe ports, so GPIO/SPI/UART/TIMER/PMC-style blocks can reuse one bus front end.
- Adds configurable grant and response wait states for slow slaves.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (1..1024).
- RO_MASK, 0 (NUM_REGS bits), bit i set = register i is read-only from the bus; hardware still updates it.
- GNT_WAIT, 0, cycles req is held before gnt (0..15).
- RSP_WAIT, 0, extra cycles between the gnt cycle and rvalid (0..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_bus  ibex_data_bus.slave  -  req/we/be/addr/wdata/wdata_intg in; gnt/rvalid/rdata/rdata_intg/err out
- regs_o  output  NUM_REGS*32  current register contents; register i = bits [32i+31:32i]
- hw_we  input  NUM_REGS  per-register hardware write enable
- hw_wdata  input  NUM_REGS*32  hardware write data, same packing as regs_o
- wr_pulse  output  NUM_REGS  one-cycle strobe when a bus write to register i commits
- rd_pulse  output  NUM_REGS  one-cycle strobe when a bus read of register i returns

Behaviour:
- Reset: state IDLE; counters 0; gnt, rvalid, err = 0; rdata = 0; regs_o = 0; wr_pulse, rd_pulse = 0. rdata_intg is tied to 0 at all times.
- Decode: index = addr[11:2]; addr[1:0] and addr[31:12] are ignored, because the arbiter has already decoded the window.
- Only one transaction is outstanding at a time.
- State machine:
  - IDLE: on req with GNT_WAIT = 0, drive gnt = 1 combinationally, capture we/be/index/wdata, go to RESPOND_WAIT. On req with GNT_WAIT > 0, load the counter and go to GRANT_WAIT.
  - GRANT_WAIT: decrement the counter while req = 1. When the counter reaches 0, drive gnt = 1, capture the request and go to RESPOND_WAIT. If req drops (protocol violation), return to IDLE with no side effects.
  - RESPOND_WAIT: gnt = 0 regardless of req. Count RSP_WAIT cycles, then go to RESPOND.
  - RESPOND: rvalid = 1 for exactly one cycle, then IDLE. A new req is only considered from IDLE, i.e. the cycle after rvalid.
- Latency: req to gnt = GNT_WAIT cycles; gnt to rvalid = 1 + RSP_WAIT cycles. Best case: gnt in cycle 0, rvalid in cycle 1.
- Read: rdata = register[index] sampled in the RESPOND cycle; rd_pulse[index] = 1 in that cycle. rdata = 0 on a write response.
- Write: commits in the RESPOND cycle. Each byte b with be[b] = 1 takes wdata[8b+7:8b]; bytes with be[b] = 0 are preserved. wr_pulse[index] = 1 in that cycle, and the new value is visible on regs_o from the next cycle.
- Hardware write: hw_we[i] loads hw_wdata[i] on every clock edge, in any state.
- Collision rule: for a read-write register, a bus write commit in the same cycle wins over hw_we. For a read-only register, hw_we always wins.
- A write with be = 0 commits nothing, but rvalid and wr_pulse are still produced.
- Error cases: index >= NUM_REGS, or a write to a read-only register, are handled per DATA_BUS_REG_RESPONDER_ERR_EN (below). Neither case ever modifies a register or raises a strobe.
- Reset mid-transaction: the transaction is dropped and no rvalid is produced; registers clear.

Optional Feature:
- Macro: DATA_BUS_REG_RESPONDER_ERR_EN.
- Defined: an error case returns err = 1 together with rvalid, with rdata = 0.
- Undefined: err is constant 0; out-of-range reads return 0 and out-of-range or read-only writes are silently dropped. The handshake timing is identical in both builds.

Test Plan:
- GNT_WAIT=0, RSP_WAIT=0: write 0xDEADBEEF be=1111 to addr 0x4, then read 0x4 -> gnt in the req cycle, rvalid 1 cycle later, rdata=0xDEADBEEF, wr_pulse[1] and rd_pulse[1] one cycle each.
- Byte enables: reg2=0x11223344, write 0xAABBCCDD be=0101 -> regs_o reg2 = 0x11BB33DD.
- GNT_WAIT=3, RSP_WAIT=2: req held -> gnt on the 4th req cycle, rvalid 3 cycles after gnt. Also drop req after 1 cycle in GRANT_WAIT -> no gnt, no rvalid, state IDLE.
- RO_MASK=0x01: bus write 0x5 to reg0 while hw_we[0]=1 with hw_wdata=0x7 -> reg0=0x7, no wr_pulse. With ERR_EN defined, err=1 on the rvalid cycle.
- NUM_REGS=8: read addr 0x40 (index 16) -> with ERR_EN: rvalid=1, err=1, rdata=0. Without ERR_EN: rvalid=1, err=0, rdata=0. No rd_pulse in either build.
- rst_n asserted in RESPOND_WAIT of a write -> no rvalid, register unchanged (reset to 0). The next req completes normally.
